// File: rtl/fmc_dvidp_input_debounce.sv
// Synchronizes the raw DIP switches and push buttons into CLK, debounces them on a
// prescaled tick, and emits one-cycle press/release/change pulses alongside the levels.
module fmc_dvidp_input_debounce #(
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 16
) (
  input  logic       CLK,
  input  logic       RESET_IN,
  input  logic [7:0] DIPSW_RAW,
  input  logic [3:0] PUSHB_RAW,
  output logic [7:0] DIPSW_OUT,
  output logic [3:0] PUSHB_OUT,
  output logic [3:0] PUSHB_PRESS,
  output logic [3:0] PUSHB_RELEASE,
  output logic       CHANGE
);

  localparam int NB = 12;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_TICKS - 1);

  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_deb;
  logic [CW-1:0] r_div;
  logic [SW-1:0] r_cnt [NB];
  logic [3:0]    r_press;
  logic [3:0]    r_release;
  logic          r_change;

  logic          w_tick;
  logic [NB-1:0] w_deb_nxt;
  logic [NB-1:0] w_upd;
  logic [SW-1:0] w_cnt_nxt [NB];

  assign w_tick = (r_div == DIV_LAST);

  // Any tick where the sample agrees with the debounced level restarts that bit's qualification.
  always_comb begin
    w_deb_nxt = r_deb;
    for (int i = 0; i < NB; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_tick) begin
        if (r_sync2[i] == r_deb[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_deb_nxt[i] = r_sync2[i];
          w_cnt_nxt[i] = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + SW'(1);
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  assign w_upd = w_deb_nxt ^ r_deb;

  // Synchronizer, prescaler, debounced state and pulses all advance on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET_IN) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_div     <= '0;
      r_deb     <= '0;
      r_press   <= 4'b0000;
      r_release <= 4'b0000;
      r_change  <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= {PUSHB_RAW, DIPSW_RAW};
      r_sync2   <= r_sync1;
      r_div     <= w_tick ? '0 : r_div + CW'(1);
      r_deb     <= w_deb_nxt;
      r_press   <= w_upd[11:8] & w_deb_nxt[11:8];
      r_release <= w_upd[11:8] & ~w_deb_nxt[11:8];
      r_change  <= |w_upd;
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign DIPSW_OUT     = r_deb[7:0];
  assign PUSHB_OUT     = r_deb[11:8];
  assign PUSHB_PRESS   = r_press;
  assign PUSHB_RELEASE = r_release;
  assign CHANGE        = r_change;

endmodule

// File: tb/tb_fmc_dvidp_input_debounce.sv
// Self-checking bench for fmc_dvidp_input_debounce (TICK_DIV=4, STABLE_TICKS=3): directed
// scenarios, a vector table and random stimulus, all compared against a tick-history model.
module tb_fmc_dvidp_input_debounce;
  localparam int TD = 4;
  localparam int ST = 3;

  logic       CLK;
  logic       RESET_IN;
  logic [7:0] DIPSW_RAW;
  logic [3:0] PUSHB_RAW;
  logic [7:0] DIPSW_OUT;
  logic [3:0] PUSHB_OUT;
  logic [3:0] PUSHB_PRESS;
  logic [3:0] PUSHB_RELEASE;
  logic       CHANGE;

  int checks   = 0;
  int failures = 0;

  fmc_dvidp_input_debounce #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .CLK(CLK), .RESET_IN(RESET_IN), .DIPSW_RAW(DIPSW_RAW), .PUSHB_RAW(PUSHB_RAW),
    .DIPSW_OUT(DIPSW_OUT), .PUSHB_OUT(PUSHB_OUT), .PUSHB_PRESS(PUSHB_PRESS),
    .PUSHB_RELEASE(PUSHB_RELEASE), .CHANGE(CHANGE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: a level is accepted once the last ST tick samples all disagree with it.
  logic [11:0] m_s1, m_s2, m_deb, m_old;
  logic [11:0] m_hist[$];
  logic [3:0]  m_press, m_rel;
  logic        m_chg;
  int          m_n;
  bit          all_diff;

  always @(posedge CLK) begin
    if (RESET_IN) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_n = 0;
      m_hist.delete();
      m_press = '0; m_rel = '0; m_chg = 1'b0;
    end else begin
      m_old = m_deb;
      if ((m_n % TD) == TD - 1) begin
        m_hist.push_back(m_s2);
        if (m_hist.size() > ST) void'(m_hist.pop_front());
        if (m_hist.size() == ST) begin
          for (int b = 0; b < 12; b++) begin
            all_diff = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == m_old[b]) all_diff = 1'b0;
            if (all_diff) m_deb[b] = m_s2[b];
          end
        end
      end
      m_press = (m_deb[11:8] ^ m_old[11:8]) & m_deb[11:8];
      m_rel   = (m_deb[11:8] ^ m_old[11:8]) & m_old[11:8];
      m_chg   = (m_deb != m_old);
      m_n++;
      m_s2 = m_s1;
      m_s1 = {PUSHB_RAW, DIPSW_RAW};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    chk("dipsw_out", 32'(DIPSW_OUT), 32'(m_deb[7:0]));
    chk("pushb_out", 32'(PUSHB_OUT), 32'(m_deb[11:8]));
    chk("pushb_press", 32'(PUSHB_PRESS), 32'(m_press));
    chk("pushb_release", 32'(PUSHB_RELEASE), 32'(m_rel));
    chk("change", 32'(CHANGE), 32'(m_chg));
    chk("prescaler", 32'(dut.r_div), 32'(m_n % TD));
    chk("tick", 32'(dut.w_tick), 32'((m_n % TD) == TD - 1));
  endtask

  // Raw was just changed; edge k (1-based) is e0+k-1, so L in 10..13 means k in 11..14.
  task automatic measure(input string nm, input logic [11:0] exp_lvl,
                         input logic [3:0] exp_press, input logic [3:0] exp_rel);
    int k;
    bit found;
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      step();
      k++;
      if ({PUSHB_OUT, DIPSW_OUT} == exp_lvl) found = 1'b1;
    end
    checks++;
    if (!found || k < 11 || k > 14) begin
      failures++;
      $display("FAIL %s_latency got_edges=%0d found=%0d required=11..14", nm, k, found);
    end
    chk({nm, "_press"}, 32'(PUSHB_PRESS), 32'(exp_press));
    chk({nm, "_release"}, 32'(PUSHB_RELEASE), 32'(exp_rel));
    chk({nm, "_change"}, 32'(CHANGE), 32'd1);
    step();
    chk({nm, "_press_end"}, 32'(PUSHB_PRESS), 32'd0);
    chk({nm, "_release_end"}, 32'(PUSHB_RELEASE), 32'd0);
    chk({nm, "_change_end"}, 32'(CHANGE), 32'd0);
  endtask

  typedef struct {
    logic [7:0] dip;
    logic [3:0] push;
    int         hold;
    logic [7:0] exp_dip;
    logic [3:0] exp_push;
  } vec_t;

  vec_t vecs[7];
  int   ticks;
  logic seen;

  initial begin
    vecs[0] = '{8'hA5, 4'h3, 16, 8'hA5, 4'h3};
    vecs[1] = '{8'hFF, 4'hF,  2, 8'hA5, 4'h3};
    vecs[2] = '{8'hA5, 4'h3, 16, 8'hA5, 4'h3};
    vecs[3] = '{8'h5A, 4'hC, 16, 8'h5A, 4'hC};
    vecs[4] = '{8'h00, 4'h0, 16, 8'h00, 4'h0};
    vecs[5] = '{8'h3C, 4'h5,  9, 8'h00, 4'h0};
    vecs[6] = '{8'h3C, 4'h5, 16, 8'h3C, 4'h5};

    // 1: reset with inputs high, then qualification on one edge
    RESET_IN = 1'b1; DIPSW_RAW = 8'hFF; PUSHB_RAW = 4'hF;
    repeat (5) step();
    chk("reset_outputs", 32'({DIPSW_OUT, PUSHB_OUT, PUSHB_PRESS, PUSHB_RELEASE, CHANGE}), 32'd0);
    RESET_IN = 1'b0;
    measure("reset_release", 12'hFFF, 4'hF, 4'h0);

    // 2: clean press and release
    DIPSW_RAW = 8'h00; PUSHB_RAW = 4'h0;
    repeat (20) step();
    chk("cleared", 32'({PUSHB_OUT, DIPSW_OUT}), 32'd0);
    PUSHB_RAW = 4'b0001;
    measure("press0", 12'h100, 4'b0001, 4'b0000);
    PUSHB_RAW = 4'b0000;
    measure("release0", 12'h000, 4'b0000, 4'b0001);

    // 3: bounce on bit 2 is rejected
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0) PUSHB_RAW[2] = ~PUSHB_RAW[2];
      step();
      seen = seen | (|PUSHB_OUT) | (|PUSHB_PRESS) | (|PUSHB_RELEASE) | CHANGE;
    end
    PUSHB_RAW[2] = 1'b0;
    repeat (20) begin
      step();
      seen = seen | (|PUSHB_OUT) | (|PUSHB_PRESS) | (|PUSHB_RELEASE) | CHANGE;
    end
    chk("bounce_quiet", 32'(seen), 32'd0);

    // 4: simultaneous change on a DIP bit and a button
    DIPSW_RAW[7] = 1'b1; PUSHB_RAW[3] = 1'b1;
    measure("simultaneous", 12'h880, 4'b1000, 4'b0000);
    DIPSW_RAW = 8'h00; PUSHB_RAW = 4'h0;
    repeat (20) step();

    // 5: reset mid-count discards progress and re-qualifies
    PUSHB_RAW[1] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen = seen | PUSHB_OUT[1];
    end
    chk("no_early_output", 32'(seen), 32'd0);
    RESET_IN = 1'b1;
    step();
    RESET_IN = 1'b0;
    measure("after_reset", 12'h200, 4'b0010, 4'b0000);

    // 6: prescaler ticks once every TD cycles
    ticks = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (dut.w_tick) ticks++;
    end
    chk("tick_count", 32'(ticks), 32'd25);

    // Vector table
    PUSHB_RAW = 4'h0; DIPSW_RAW = 8'h00;
    repeat (20) step();
    for (int v = 0; v < 7; v++) begin
      DIPSW_RAW = vecs[v].dip;
      PUSHB_RAW = vecs[v].push;
      repeat (vecs[v].hold) step();
      chk($sformatf("vec%0d_dip", v), 32'(DIPSW_OUT), 32'(vecs[v].exp_dip));
      chk($sformatf("vec%0d_push", v), 32'(PUSHB_OUT), 32'(vecs[v].exp_push));
    end

    // Random stimulus against the model
    for (int r = 0; r < 250; r++) begin
      if ($urandom_range(0, 49) == 0) begin
        RESET_IN = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        RESET_IN = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin
        DIPSW_RAW = DIPSW_RAW ^ 8'($urandom_range(0, 255));
        PUSHB_RAW = PUSHB_RAW ^ 4'($urandom_range(0, 15));
      end else begin
        PUSHB_RAW[$urandom_range(0, 3)] = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(1, 16)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
